// File: rtl/mem_arbiter_if.sv
// Bundle between cache clients, the line arbiter and the cacheline adaptor.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [LINE_W-1:0]        mem_rdata;
    logic                     mem_resp;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    modport slave (
        input  ch_addr, ch_wdata, ch_read, ch_write, mem_rdata, mem_resp,
        output ch_rdata, ch_resp, mem_addr, mem_wdata, mem_read, mem_write,
               grant_id, busy
    );

    modport master (
        output ch_addr, ch_wdata, ch_read, ch_write, mem_rdata, mem_resp,
        input  ch_rdata, ch_resp, mem_addr, mem_wdata, mem_read, mem_write,
               grant_id, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel cache-line arbiter onto a single memory line port; the grant is
// held for a whole transaction, fixed-priority (MODE 0) or round-robin (MODE 1).
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int MODE   = 0
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int              ID_W = $clog2(NUM_CH);
    localparam logic [ID_W:0]   NCH  = (ID_W+1)'(NUM_CH);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_CH - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              read_q;
    logic              write_q;

    logic [NUM_CH-1:0] req;
    logic [ID_W-1:0]   start;
    logic [ID_W:0]     scan;
    logic [ID_W-1:0]   win;
    logic              win_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_write;
    logic              resp_fire;

    assign req   = bus.ch_read | bus.ch_write;
    assign start = (MODE == 1) ? rr_ptr_q : '0;

    // Circular scan from start; the extra bit in scan absorbs the wrap.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        scan    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            scan = {1'b0, start} + (ID_W+1)'(k);
            if (scan >= NCH) scan = scan - NCH;
            if (!win_vld && req[scan[ID_W-1:0]]) begin
                win_vld = 1'b1;
                win     = scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (win == ID_W'(i)) begin
                sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.ch_wdata[i*LINE_W +: LINE_W];
                sel_write = bus.ch_write[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q <= BUSY;
                        grant_q <= win;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        write_q <= sel_write;
                        read_q  <= !sel_write;
                    end
                end
                BUSY: begin
                    if (bus.mem_resp) begin
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (MODE == 1)
                            rr_ptr_q <= (grant_q == LAST) ? '0 : grant_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_fire = (state_q == BUSY) && bus.mem_resp;

    always_comb begin
        bus.ch_resp = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            bus.ch_resp[i] = resp_fire && (grant_q == ID_W'(i));
    end

    assign bus.ch_rdata  = bus.mem_rdata;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_read  = read_q;
    assign bus.mem_write = write_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == BUSY);
endmodule

// File: tb/tb_mem_arbiter.sv
// Random-stimulus scoreboard bench: a 2-channel fixed-priority arbiter and a
// 4-channel round-robin arbiter run side by side against a transaction model.
module tb_mem_arbiter;
    typedef struct packed {
        logic [1:0]   ch;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    // Index 0: NUM_CH=2 MODE=0, index 1: NUM_CH=4 MODE=1.
    logic [3:0]   rd[2];
    logic [3:0]   wr[2];
    logic [31:0]  addr[2][4];
    logic [255:0] wd[2][4];
    logic         mresp[2];
    logic [255:0] mrdata[2];

    logic [3:0]   cresp[2];
    logic [255:0] crdata[2];
    logic [31:0]  maddr[2];
    logic [255:0] mwdata[2];
    logic         mrd[2];
    logic         mwr[2];
    logic         busy_o[2];
    logic [1:0]   gid[2];

    bit         m_busy[2];
    logic [1:0] m_ch[2];
    int         m_rr[2];
    bit         done[2][4];
    txn_t       q0[$];
    txn_t       q1[$];
    txn_t       cur[2];
    bit         prev_req[2];
    bit         act[2];
    int         wt[2];
    bit         hold;
    bit         chk_en;
    int         n_chk;
    int         n_fail;

    mem_arbiter_if #(.NUM_CH(2), .LINE_W(256), .ADDR_W(32)) ifa ();
    mem_arbiter_if #(.NUM_CH(4), .LINE_W(256), .ADDR_W(32)) ifb ();

    mem_arbiter #(.NUM_CH(2), .LINE_W(256), .ADDR_W(32), .MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    mem_arbiter #(.NUM_CH(4), .LINE_W(256), .ADDR_W(32), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    assign ifa.ch_read   = rd[0][1:0];
    assign ifa.ch_write  = wr[0][1:0];
    assign ifa.ch_addr   = {addr[0][1], addr[0][0]};
    assign ifa.ch_wdata  = {wd[0][1], wd[0][0]};
    assign ifa.mem_rdata = mrdata[0];
    assign ifa.mem_resp  = mresp[0];
    assign ifb.ch_read   = rd[1];
    assign ifb.ch_write  = wr[1];
    assign ifb.ch_addr   = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
    assign ifb.ch_wdata  = {wd[1][3], wd[1][2], wd[1][1], wd[1][0]};
    assign ifb.mem_rdata = mrdata[1];
    assign ifb.mem_resp  = mresp[1];

    always_comb begin
        cresp[0]  = {2'b00, ifa.ch_resp};
        crdata[0] = ifa.ch_rdata;
        maddr[0]  = ifa.mem_addr;
        mwdata[0] = ifa.mem_wdata;
        mrd[0]    = ifa.mem_read;
        mwr[0]    = ifa.mem_write;
        busy_o[0] = ifa.busy;
        gid[0]    = {1'b0, ifa.grant_id};
        cresp[1]  = ifb.ch_resp;
        crdata[1] = ifb.ch_rdata;
        maddr[1]  = ifb.mem_addr;
        mwdata[1] = ifb.mem_wdata;
        mrd[1]    = ifb.mem_read;
        mwr[1]    = ifb.mem_write;
        busy_o[1] = ifb.busy;
        gid[1]    = ifb.grant_id;
    end

    task automatic chk(input bit ok, input string msg);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s", msg);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int nch(input int d);
        return (d == 1) ? 4 : 2;
    endfunction

    // Transaction model: one grant per idle edge, completion on mem_resp.
    task automatic model_step(input int d);
        int   n;
        int   start;
        int   w;
        int   c;
        txn_t t;
        n = nch(d);
        if (m_busy[d]) begin
            if (mresp[d]) begin
                m_busy[d] = 1'b0;
                done[d][m_ch[d]] = 1'b1;
                if (d == 1) m_rr[d] = (int'(m_ch[d]) + 1) % n;
            end
        end else begin
            start = (d == 1) ? m_rr[d] : 0;
            w = -1;
            for (int k = 0; k < n; k++) begin
                c = (start + k) % n;
                if (w < 0 && (rd[d][c] || wr[d][c])) w = c;
            end
            if (w >= 0) begin
                t.ch    = 2'(w);
                t.wr    = wr[d][w];
                t.addr  = addr[d][w];
                t.wdata = wd[d][w];
                if (d == 0) q0.push_back(t);
                else        q1.push_back(t);
                m_busy[d] = 1'b1;
                m_ch[d]   = 2'(w);
            end
        end
    endtask

    task automatic drive(input int d, input int rate);
        int op;
        for (int c = 0; c < nch(d); c++) begin
            if (done[d][c]) begin
                rd[d][c]   = 1'b0;
                wr[d][c]   = 1'b0;
                done[d][c] = 1'b0;
            end else if (m_busy[d] && m_ch[d] == 2'(c)) begin
                // The granted client wiggles its inputs; the arbiter must ignore them.
                if ($urandom_range(0, 3) == 0) begin
                    rd[d][c]   = 1'($urandom_range(0, 1));
                    wr[d][c]   = 1'($urandom_range(0, 1));
                    addr[d][c] = $urandom;
                    wd[d][c]   = rand_line();
                end
            end else if (!(rd[d][c] || wr[d][c]) && $urandom_range(0, 99) < rate) begin
                op = int'($urandom_range(0, 2));
                rd[d][c]   = (op != 1);
                wr[d][c]   = (op != 0);
                addr[d][c] = $urandom;
                wd[d][c]   = rand_line();
            end
        end
        mrdata[d] = rand_line();
        if (mresp[d]) begin
            mresp[d] = 1'b0;
        end else begin
            if (!act[d] && (mrd[d] || mwr[d]) && !hold) begin
                act[d] = 1'b1;
                wt[d]  = int'($urandom_range(0, 3));
            end
            if (act[d]) begin
                if (wt[d] == 0) begin
                    mresp[d] = 1'b1;
                    act[d]   = 1'b0;
                end else begin
                    wt[d]--;
                end
            end else if (!(mrd[d] || mwr[d]) && $urandom_range(0, 15) == 0) begin
                mresp[d] = 1'b1;
            end
        end
    endtask

    task automatic run_cycles(input int n, input int rate);
        repeat (n) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            drive(0, rate);
            drive(1, rate);
        end
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        chk(mrd[d] === 1'b0 && mwr[d] === 1'b0,
            $sformatf("%s[%0d] mem_read/mem_write got %b%b want 00", tag, d, mrd[d], mwr[d]));
        chk(busy_o[d] === 1'b0, $sformatf("%s[%0d] busy got %b want 0", tag, d, busy_o[d]));
        chk(cresp[d] === 4'h0, $sformatf("%s[%0d] ch_resp got %h want 0", tag, d, cresp[d]));
        chk(maddr[d] === 32'h0 && gid[d] === 2'd0 && mwdata[d] === '0,
            $sformatf("%s[%0d] mem_addr/grant_id got %h/%0d want 0/0", tag, d, maddr[d], gid[d]));
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_resp;
        txn_t       t;
        bit         got;
        for (int d = 0; d < 2; d++) begin
            if (chk_en) begin
                exp_resp = (m_busy[d] && mresp[d]) ? (4'b0001 << m_ch[d]) : 4'b0000;
                chk(cresp[d] === exp_resp,
                    $sformatf("ch_resp[%0d] got %h want %h", d, cresp[d], exp_resp));
                chk(crdata[d] === mrdata[d],
                    $sformatf("ch_rdata[%0d] got %h want %h", d, crdata[d], mrdata[d]));
                chk(busy_o[d] === m_busy[d],
                    $sformatf("busy[%0d] got %b want %b", d, busy_o[d], m_busy[d]));
                if ((mrd[d] || mwr[d]) && !prev_req[d]) begin
                    got = 1'b0;
                    if (d == 0 && q0.size() > 0) begin t = q0.pop_front(); got = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin t = q1.pop_front(); got = 1'b1; end
                    chk(got, $sformatf("grant[%0d] got unexpected request want none", d));
                    if (got) begin
                        cur[d] = t;
                        chk(gid[d] === t.ch,
                            $sformatf("grant_id[%0d] got %0d want %0d", d, gid[d], t.ch));
                        chk(mwdata[d] === t.wdata,
                            $sformatf("mem_wdata[%0d] got %h want %h", d, mwdata[d], t.wdata));
                    end
                end
                if (m_busy[d]) begin
                    chk(mwr[d] === cur[d].wr && mrd[d] === !cur[d].wr,
                        $sformatf("mem_op[%0d] got r%b w%b want w%b", d, mrd[d], mwr[d], cur[d].wr));
                    chk(maddr[d] === cur[d].addr,
                        $sformatf("mem_addr[%0d] got %h want %h", d, maddr[d], cur[d].addr));
                end else begin
                    chk(!mrd[d] && !mwr[d],
                        $sformatf("idle_ctrl[%0d] got r%b w%b want 00", d, mrd[d], mwr[d]));
                end
            end
            prev_req[d] = mrd[d] || mwr[d];
        end
    end

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_ch[d]   = 2'd0;
            m_rr[d]   = 0;
            act[d]    = 1'b0;
            wt[d]     = 0;
            mresp[d]  = 1'b0;
            for (int c = 0; c < 4; c++) done[d][c] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        hold   = 1'b0;
        chk_en = 1'b0;
        rst    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 4'h0;
            wr[d] = 4'h0;
            mrdata[d] = '0;
            prev_req[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                addr[d][c] = 32'h0;
                wd[d][c]   = '0;
            end
        end
        reset_model();
        #2;
        check_reset_outputs(0, "reset");
        check_reset_outputs(1, "reset");
        #10;
        rst    = 1'b1;
        chk_en = 1'b1;

        // Moderate random load, then saturation for round-robin fairness.
        run_cycles(400, 20);
        run_cycles(300, 100);
        run_cycles(40, 0);

        // Move the round-robin pointer away from 0 before the reset test.
        addr[1][1] = 32'h0000_2000;
        rd[1][1]   = 1'b1;
        run_cycles(12, 0);

        // Park a channel-1 write on the 2-channel arbiter with no response.
        hold     = 1'b1;
        addr[0][1] = 32'h0000_3080;
        wd[0][1]   = rand_line();
        wr[0][1]   = 1'b1;
        run_cycles(3, 0);
        chk(mwr[0] === 1'b1 && gid[0] === 2'd1,
            $sformatf("pre_reset write got w%b id%0d want w1 id1", mwr[0], gid[0]));
        chk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs(0, "async_reset");
        check_reset_outputs(1, "async_reset");
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_model();
        rst  = 1'b1;
        hold = 1'b0;
        #1;
        check_reset_outputs(0, "post_reset");
        // All four request together: a reset pointer grants channel 0 first.
        for (int c = 0; c < 4; c++) begin
            addr[1][c] = $urandom;
            wd[1][c]   = rand_line();
            rd[1][c]   = 1'b1;
        end
        chk_en = 1'b1;
        run_cycles(300, 40);
        run_cycles(40, 0);

        chk(q0.size() == 0 && q1.size() == 0,
            $sformatf("pending grants got %0d/%0d want 0/0", q0.size(), q1.size()));
        chk(!m_busy[0] && !m_busy[1] && !busy_o[0] && !busy_o[1],
            $sformatf("drained busy got %b%b want 00", busy_o[0], busy_o[1]));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
